// File: rtl/multiword_add_sequencer.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit ripple slice per clock, LSB slice first,
// with valid/ready on both sides. Optional macro ADDSEQ_SUB_EN adds a `sub` port for a-b.
module multiword_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             abort,
`ifdef ADDSEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [IDXW-1:0]  idx_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             cout_reg;

  logic [3:0]       a_slice [NSLICE];
  logic [3:0]       b_slice [NSLICE];
  logic [4:0]       slice_result;
  logic             last_slice;
  logic             accept;
  logic             run_step;
  logic [WIDTH-1:0] b_operand;
  logic             cin_operand;

  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[4*gi +: 4];
      assign b_slice[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  // The single shared 4-bit datapath.
  assign slice_result = {1'b0, a_slice[idx_reg]} + {1'b0, b_slice[idx_reg]} + {4'b0000, carry_reg};
  assign last_slice   = (idx_reg == IDXW'(NSLICE - 1));
  assign accept       = in_valid & in_ready;
  assign run_step     = (state_reg == RUN) & ~abort;

`ifdef ADDSEQ_SUB_EN
  // Subtraction as a + ~b + 1; carry_out=1 then means no borrow.
  assign b_operand   = sub ? ~b : b;
  assign cin_operand = sub | carry_in;
`else
  assign b_operand   = b;
  assign cin_operand = carry_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (last_slice) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = accept ? RUN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b_operand;
      carry_reg <= cin_operand;
      idx_reg   <= '0;
    end else if (run_step) begin
      carry_reg <= slice_result[4];
      if (last_slice) begin
        cout_reg <= slice_result[4];
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg <= '0;
    end else if (run_step) begin
      for (int i = 0; i < NSLICE; i++) begin
        if (idx_reg == IDXW'(i)) begin
          sum_reg[4*i +: 4] <= slice_result[3:0];
        end
      end
    end
  end

  assign sum       = sum_reg;
  assign carry_out = cout_reg;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer (WIDTH=16): stimulus pushes expected
// {carry_out,sum}; a negedge monitor pops and compares on every result handshake.
module tb_multiword_add_sequencer;
  localparam int W = 16;
  localparam int NS = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         carry_in, abort;
`ifdef ADDSEQ_SUB_EN
  logic         sub;
`endif
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         carry_out, busy;

  int checks = 0;
  int failures = 0;
  logic [W:0] exp_q[$];

  multiword_add_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .abort(abort),
`ifdef ADDSEQ_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Result monitor: one line per output transaction.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [W:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result actual=%h/%b expected=none", sum, carry_out);
      end else begin
        e = exp_q.pop_front();
        $display("result sum=%h carry_out=%b expected sum=%h carry_out=%b", sum, carry_out, e[W-1:0], e[W]);
        if ({carry_out, sum} !== e) begin
          failures++;
          $display("FAIL result actual=%h expected=%h", {carry_out, sum}, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait (bounded) for in_ready, push expected, complete the accept edge.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                       input logic vs, input logic [W:0] expv);
    int n;
    a = va; b = vb; carry_in = vc; in_valid = 1'b1;
`ifdef ADDSEQ_SUB_EN
    sub = vs;
`endif
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    exp_q.push_back(expv);
    cyc();
    in_valid = 1'b0;
`ifdef ADDSEQ_SUB_EN
    sub = 1'b0;
`endif
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(out_valid), 32'd1);
  endtask

  // Issue with out_ready=1 and check RUN-phase handshake signals and exact latency.
  task automatic run_checked(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                             input logic vc, input logic [W:0] expv);
    out_ready = 1'b1;
    issue(va, vb, vc, 1'b0, expv);
    for (int i = 0; i < NS; i++) begin
      @(negedge clk);
      check({nm, "_run_out_valid"}, 32'(out_valid), 32'd0);
      check({nm, "_run_in_ready"}, 32'(in_ready), 32'd0);
      check({nm, "_run_busy"}, 32'(busy), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    check({nm, "_latency_out_valid"}, 32'(out_valid), 32'd1);
    check({nm, "_done_busy"}, 32'(busy), 32'd1);
    cyc();
    @(negedge clk);
    check({nm, "_after_busy"}, 32'(busy), 32'd0);
    check({nm, "_after_in_ready"}, 32'(in_ready), 32'd1);
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
`ifdef ADDSEQ_SUB_EN
    sub = 1'b0;
`endif
    #2;
    check("reset_sum", 32'(sum), 32'h0);
    check("reset_carry_out", 32'(carry_out), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;
    cyc();

    run_checked("t1", 16'hFFFF, 16'h0001, 1'b0, 17'h1_0000);
    run_checked("t2", 16'h1234, 16'h4321, 1'b1, 17'h0_5556);
    run_checked("chain", 16'hA5A5, 16'h5A5A, 1'b1, 17'h1_0000);
    run_checked("mixed", 16'h0F0F, 16'h0101, 1'b0, 17'h0_1010);

    // Backpressure, then back-to-back accept from DONE.
    out_ready = 1'b0;
    issue(16'h0003, 16'h0004, 1'b0, 1'b0, 17'h0_0007);
    wait_valid("bp_valid");
    a = 16'h0001; b = 16'h0001; carry_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum_held", 32'(sum), 32'h0007);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    cyc();
    out_ready = 1'b1;
    exp_q.push_back(17'h0_0002);
    @(negedge clk);
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_valid("b2b_valid");
    cyc();
    cyc();

    // Abort on the 3rd RUN cycle: result discarded.
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h0);
    void'(exp_q.pop_back());
    cyc();
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    cyc();

    // Asynchronous reset in the 2nd RUN cycle.
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 17'h0);
    void'(exp_q.pop_back());
    cyc();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_carry_out", 32'(carry_out), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    run_checked("t5", 16'h8000, 16'h8000, 1'b0, 17'h1_0000);

`ifdef ADDSEQ_SUB_EN
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0_FFFE);
    wait_valid("sub1_valid");
    cyc();
    issue(16'h0007, 16'h0005, 1'b0, 1'b1, 17'h1_0002);
    wait_valid("sub2_valid");
    cyc();
`endif

    repeat (4) cyc();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
